phv_merge: RTL and testbench
============================

# phv_merge

Downstream neighbour of the action-stage `crossbar` and its ALU array. It collects the per-group ALU results (6B, 4B and 2B containers) and the untouched `phv_remain_data` forwarded by `crossbar`. These can arrive in different cycles, so each stream is buffered in its own FIFO and matched in order. When one set is complete, the block rebuilds the full PHV and hands it to the next stage over a valid/ready handshake.

## Interface
Parameters:
- `STAGE`, 0, stage index; no functional effect.
- `PHV_LEN`, 1124, full PHV width; must equal 8*`width_6B` + 8*`width_4B` + 8*`width_2B` + `REMAIN_LEN`.
- `width_2B`, 16, 2-byte container width.
- `width_4B`, 32, 4-byte container width.
- `width_6B`, 48, 6-byte container width.
- `REMAIN_LEN`, 356, width of the pass-through PHV tail (metadata plus 100-bit container map).
- `FIFO_DEPTH`, 4, entries per FIFO; power of two, minimum 2.

Ports:
- `clk` in 1: single clock domain.
- `rst_n` in 1: reset, asynchronous, active-low.
- `phv_remain_data` in 356: PHV tail from `crossbar`.
- `remain_valid` in 1: driven by the `crossbar` `alu_in_valid` output.
- `alu_out_6B` in 384: eight 6B results; container 7 in the MSBs.
- `alu_out_6B_valid` in 1: strobe for `alu_out_6B`.
- `alu_out_4B` in 256: eight 4B results; container 7 in the MSBs.
- `alu_out_4B_valid` in 1: strobe for `alu_out_4B`.
- `alu_out_2B` in 128: eight 2B results; container 7 in the MSBs.
- `alu_out_2B_valid` in 1: strobe for `alu_out_2B`.
- `phv_out` out 1124: rebuilt PHV.
- `phv_out_valid` out 1: `phv_out` holds a valid PHV.
- `phv_out_ready` in 1: next stage accepts the PHV.
- `ready_out` out 1: upstream may issue a new PHV into `crossbar`.
- `overflow_err` out 1: sticky flag, set when any FIFO receives a push while full.

## Operation
- Four independent FIFOs: REM, R6, R4, R2.
  - Each holds `FIFO_DEPTH` entries and has a counter of `log2(FIFO_DEPTH)`+1 bits.
  - A FIFO pushes in any cycle where its valid input is high.
- Groups may arrive in any order relative to each other. Within a group, arrival order always equals issue order.
- Merge condition: all four FIFOs are non-empty AND (`phv_out_valid`==0 OR `phv_out_ready`==1).
- When the merge condition holds:
  - All four FIFOs pop their head entry in the same cycle.
  - `phv_out` is loaded with `{R6 head, R4 head, R2 head, REM head}`, so the 6B container 7 lands at PHV bits [1123:1076].
  - `phv_out_valid` is set to 1.
- Output hold and clear:
  - While `phv_out_valid`==1 and `phv_out_ready`==0, `phv_out` holds stable.
  - When `phv_out_ready`==1 and no new merge is possible, `phv_out_valid` clears to 0 on the next edge.
- Push on a full FIFO:
  - If a pop happens in the same cycle, the push is accepted and the count is unchanged.
  - If there is no pop, the data is dropped, the count is unchanged and `overflow_err` is set to 1. The flag clears only on reset.
- Simultaneous push and pop on an empty FIFO: no bypass. The pushed entry becomes visible on the next cycle.
- `ready_out` = (REM count < `FIFO_DEPTH`-1). This is combinational from the registered count and leaves one slot for a PHV already inside `crossbar`.
- Pointers wrap modulo `FIFO_DEPTH`.
- No data-dependent behaviour: all payloads are opaque.

## Timing
- Reset values, applied asynchronously while `rst_n`=0:
  - `phv_out`=0, `phv_out_valid`=0, `overflow_err`=0.
  - All FIFO pointers and counters are 0, so `ready_out`=1.
- Reset asserted mid-operation: all buffered and in-flight entries are discarded immediately. The first valid after deassertion is treated as a new PHV.
- Latency: `phv_out_valid` rises 2 edges after the edge that samples the last-arriving component. One edge writes the FIFO; the next edge merges.
- Throughput: one PHV per cycle while all FIFOs are non-empty and `phv_out_ready`=1.
- No combinational path from any input to `phv_out`/`phv_out_valid`. `phv_out_ready` reaches only FIFO pop and output-register enables.

## Test plan
- **Single PHV, aligned.**
  - Stimulus: `remain_valid` with `phv_remain_data`=356'h1; all three ALU valids 2 cycles later, with `alu_out_6B`={48'hfffffffffffe,48'heeeeeeeeeeef,288'b0}, 4B/2B = 0; `phv_out_ready`=1.
  - Response: `phv_out`={48'hfffffffffffe,48'heeeeeeeeeeef,672'b0,355'b0,1'b1}; valid for exactly 1 cycle.
- **Skewed groups.**
  - Stimulus: REM at cycle 0, 2B at cycle 1, 4B at cycle 3, 6B at cycle 5.
  - Response: `phv_out_valid` stays 0 until the cycle after the 6B push becomes visible; the merged value is correct.
- **Backpressure.**
  - Stimulus: 3 complete PHVs tagged REM=1,2,3; `phv_out_ready`=0 for 6 cycles, then 1.
  - Response: `phv_out` holds tag 1 throughout the stall, then outputs 1,2,3 on consecutive cycles; `overflow_err`=0.
- **Fill and overflow.**
  - Stimulus: 4 REM pushes with no ALU results.
  - Response: `ready_out` falls to 0 when the count reaches 3; a 5th REM push is dropped, `overflow_err`=1 and stays 1.
- **Full with simultaneous push/pop.**
  - Stimulus: REM full, R6/R4/R2 each holding 1 entry, `phv_out_ready`=1, new REM push in the same cycle.
  - Response: the push is accepted, the count stays at 4, `overflow_err` stays 0, and order is preserved.
- **Reset mid-stream.**
  - Stimulus: assert `rst_n`=0 asynchronously between edges with 2 PHVs buffered and `phv_out_valid`=1.
  - Response: outputs go to reset values immediately, and the next complete PHV after release is the first output.

Source files
------------

// File: rtl/phv_merge.sv
// -----------------------------------------------------------------------------
// phv_merge
//
// Collects the three per-group ALU result vectors (6B, 4B, 2B containers) and
// the pass-through PHV tail forwarded by the crossbar. Each of the four
// streams is buffered in its own in-order FIFO because the components can
// arrive in different cycles. Once every FIFO holds at least one entry, the
// heads are popped together and reassembled into a full PHV. The PHV is then
// presented on a valid/ready output register.
//
// Ports:
//   clk, rst_n         clock; asynchronous active-low reset
//   phv_remain_data    PHV tail (metadata + container map) from the crossbar
//   remain_valid       push strobe for phv_remain_data
//   alu_out_6B/_valid  eight 6B results (container 7 in MSBs) + push strobe
//   alu_out_4B/_valid  eight 4B results (container 7 in MSBs) + push strobe
//   alu_out_2B/_valid  eight 2B results (container 7 in MSBs) + push strobe
//   phv_out            rebuilt PHV {6B, 4B, 2B, tail}
//   phv_out_valid      phv_out holds a PHV
//   phv_out_ready      downstream accepts phv_out
//   ready_out          upstream may issue another PHV into the crossbar
//   overflow_err       sticky: some FIFO was pushed while full without a pop
// -----------------------------------------------------------------------------

// Simple in-order FIFO. The caller only pops when the FIFO is non-empty.
// A push while full is accepted only if a pop frees a slot in the same cycle.
// The head is read straight from storage. A push into an empty FIFO therefore
// becomes visible one cycle later, and there is no bypass path.
//   push, data_in : write request and payload
//   pop           : remove head entry
//   head          : current head entry
//   count         : number of stored entries (0..DEPTH)
module phv_merge_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               data_in,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          wr_en;

  assign full  = (count == CW'(DEPTH));
  assign wr_en = push && (!full || pop);
  assign head  = mem[rd_ptr];

  // NOTE: storage carries no reset; pointers and count define which entries
  // are live, so resetting the array would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= data_in;
  end

  // Pointers are PW bits wide, so DEPTH being a power of two makes them wrap
  // naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

module phv_merge #(
  parameter int STAGE      = 0,
  parameter int PHV_LEN    = 1124,
  parameter int width_2B   = 16,
  parameter int width_4B   = 32,
  parameter int width_6B   = 48,
  parameter int REMAIN_LEN = 356,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [REMAIN_LEN-1:0]   phv_remain_data,
  input  logic                    remain_valid,
  input  logic [8*width_6B-1:0]   alu_out_6B,
  input  logic                    alu_out_6B_valid,
  input  logic [8*width_4B-1:0]   alu_out_4B,
  input  logic                    alu_out_4B_valid,
  input  logic [8*width_2B-1:0]   alu_out_2B,
  input  logic                    alu_out_2B_valid,
  output logic [PHV_LEN-1:0]      phv_out,
  output logic                    phv_out_valid,
  input  logic                    phv_out_ready,
  output logic                    ready_out,
  output logic                    overflow_err
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] READY_LIM = CW'(FIFO_DEPTH - 1);

  logic [REMAIN_LEN-1:0] rem_head;
  logic [8*width_6B-1:0] r6_head;
  logic [8*width_4B-1:0] r4_head;
  logic [8*width_2B-1:0] r2_head;
  logic [CW-1:0]         rem_count, r6_count, r4_count, r2_count;
  logic                  merge;
  logic                  overflow_now;

  // All four FIFOs pop together, so one merge strobe serves as every pop.
  assign merge = (rem_count != '0) && (r6_count != '0) &&
                 (r4_count != '0) && (r2_count != '0) &&
                 (!phv_out_valid || phv_out_ready);

  phv_merge_fifo #(.W(REMAIN_LEN), .DEPTH(FIFO_DEPTH)) u_rem (
    .clk(clk), .rst_n(rst_n), .push(remain_valid), .data_in(phv_remain_data),
    .pop(merge), .head(rem_head), .count(rem_count)
  );

  phv_merge_fifo #(.W(8*width_6B), .DEPTH(FIFO_DEPTH)) u_r6 (
    .clk(clk), .rst_n(rst_n), .push(alu_out_6B_valid), .data_in(alu_out_6B),
    .pop(merge), .head(r6_head), .count(r6_count)
  );

  phv_merge_fifo #(.W(8*width_4B), .DEPTH(FIFO_DEPTH)) u_r4 (
    .clk(clk), .rst_n(rst_n), .push(alu_out_4B_valid), .data_in(alu_out_4B),
    .pop(merge), .head(r4_head), .count(r4_count)
  );

  phv_merge_fifo #(.W(8*width_2B), .DEPTH(FIFO_DEPTH)) u_r2 (
    .clk(clk), .rst_n(rst_n), .push(alu_out_2B_valid), .data_in(alu_out_2B),
    .pop(merge), .head(r2_head), .count(r2_count)
  );

  // A data drop happens only when the FIFO is full and no merge frees a slot.
  assign overflow_now = !merge && (
                          (remain_valid     && rem_count == FULL_CNT) ||
                          (alu_out_6B_valid && r6_count  == FULL_CNT) ||
                          (alu_out_4B_valid && r4_count  == FULL_CNT) ||
                          (alu_out_2B_valid && r2_count  == FULL_CNT));

  // One slot is kept in reserve for a PHV already in flight inside the crossbar.
  assign ready_out = (rem_count < READY_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phv_out       <= '0;
      phv_out_valid <= 1'b0;
      overflow_err  <= 1'b0;
    end else begin
      if (merge) begin
        phv_out       <= {r6_head, r4_head, r2_head, rem_head};
        phv_out_valid <= 1'b1;
      end else if (phv_out_ready) begin
        phv_out_valid <= 1'b0;
      end
      if (overflow_now) overflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_phv_merge.sv
// -----------------------------------------------------------------------------
// tb_phv_merge
//
// Self-checking bench for phv_merge. Expected PHVs are pushed to a scoreboard
// queue as stimulus is issued. A monitor pops and compares one entry on every
// output handshake. Layout vectors come from a table. The multi-cycle corner
// cases (latency, skew, backpressure, full FIFOs, overflow and reset) are
// hand-written sequences.
// -----------------------------------------------------------------------------
module tb_phv_merge;

  localparam int PHV_LEN = 1124;
  localparam int REM     = 356;
  localparam int W6      = 384;
  localparam int W4      = 256;
  localparam int W2      = 128;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [REM-1:0]     phv_remain_data;
  logic               remain_valid;
  logic [W6-1:0]      alu_out_6B;
  logic               alu_out_6B_valid;
  logic [W4-1:0]      alu_out_4B;
  logic               alu_out_4B_valid;
  logic [W2-1:0]      alu_out_2B;
  logic               alu_out_2B_valid;
  logic [PHV_LEN-1:0] phv_out;
  logic               phv_out_valid;
  logic               phv_out_ready;
  logic               ready_out;
  logic               overflow_err;

  phv_merge dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .phv_remain_data  (phv_remain_data),
    .remain_valid     (remain_valid),
    .alu_out_6B       (alu_out_6B),
    .alu_out_6B_valid (alu_out_6B_valid),
    .alu_out_4B       (alu_out_4B),
    .alu_out_4B_valid (alu_out_4B_valid),
    .alu_out_2B       (alu_out_2B),
    .alu_out_2B_valid (alu_out_2B_valid),
    .phv_out          (phv_out),
    .phv_out_valid    (phv_out_valid),
    .phv_out_ready    (phv_out_ready),
    .ready_out        (ready_out),
    .overflow_err     (overflow_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [PHV_LEN-1:0] sb_q[$];

  typedef struct {
    logic [REM-1:0]     rem;
    logic [W6-1:0]      d6;
    logic [W4-1:0]      d4;
    logic [W2-1:0]      d2;
    logic [PHV_LEN-1:0] exp;
  } vec_t;

  vec_t tbl[5];

  task automatic check_bit(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_phv(input string name, input logic [PHV_LEN-1:0] act,
                           input logic [PHV_LEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got top48=%h low64=%h expected top48=%h low64=%h",
               name, act[PHV_LEN-1 -: 48], act[63:0], exp[PHV_LEN-1 -: 48], exp[63:0]);
    end
  endtask

  // Tag-derived payloads: each group carries a distinct pattern so a swapped
  // or misplaced group shows up in the merged PHV.
  function automatic logic [W6-1:0] mk6(input int tag);
    return {8{16'h6600, 32'(tag)}};
  endfunction
  function automatic logic [W4-1:0] mk4(input int tag);
    return {8{32'h44440000 ^ 32'(tag)}};
  endfunction
  function automatic logic [W2-1:0] mk2(input int tag);
    return {8{16'h2200 + 16'(tag)}};
  endfunction
  function automatic logic [REM-1:0] mk_rem(input int tag);
    return REM'(tag);
  endfunction
  function automatic logic [PHV_LEN-1:0] mk_phv(input int tag);
    return {mk6(tag), mk4(tag), mk2(tag), mk_rem(tag)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    remain_valid     = 1'b0;
    alu_out_6B_valid = 1'b0;
    alu_out_4B_valid = 1'b0;
    alu_out_2B_valid = 1'b0;
  endtask

  task automatic send(input bit rv, input bit v6, input bit v4, input bit v2, input int tag);
    remain_valid     = rv;
    alu_out_6B_valid = v6;
    alu_out_4B_valid = v4;
    alu_out_2B_valid = v2;
    phv_remain_data  = mk_rem(tag);
    alu_out_6B       = mk6(tag);
    alu_out_4B       = mk4(tag);
    alu_out_2B       = mk2(tag);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    idle();
    phv_out_ready = 1'b0;
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  // Scoreboard monitor: the handshake is sampled mid-cycle, so the transfer
  // it sees completes on the following rising edge.
  always @(negedge clk) begin
    if (rst_n && phv_out_valid && phv_out_ready) begin
      if (sb_q.size() == 0) begin
        check_bit("sb_unexpected", 64'd1, 64'd0);
      end else begin
        check_phv("sb_data", phv_out, sb_q.pop_front());
      end
    end
  end

  initial begin
    tbl[0].rem = '1; tbl[0].d6 = '0; tbl[0].d4 = '0; tbl[0].d2 = '0;
    tbl[0].exp = {{(PHV_LEN-REM){1'b0}}, {REM{1'b1}}};
    tbl[1].rem = '0; tbl[1].d6 = '1; tbl[1].d4 = '0; tbl[1].d2 = '0;
    tbl[1].exp = {{W6{1'b1}}, {(PHV_LEN-W6){1'b0}}};
    tbl[2].rem = '0; tbl[2].d6 = '0; tbl[2].d4 = '1; tbl[2].d2 = '0;
    tbl[2].exp = {384'b0, {256{1'b1}}, 484'b0};
    tbl[3].rem = '0; tbl[3].d6 = '0; tbl[3].d4 = '0; tbl[3].d2 = '1;
    tbl[3].exp = {640'b0, {128{1'b1}}, 356'b0};
    tbl[4].rem = {89{4'ha}}; tbl[4].d6 = {96{4'h5}}; tbl[4].d4 = {64{4'hc}}; tbl[4].d2 = {32{4'h3}};
    tbl[4].exp = {{96{4'h5}}, {64{4'hc}}, {32{4'h3}}, {89{4'ha}}};

    rst_n = 1'b0;
    phv_out_ready = 1'b0;
    send(0, 0, 0, 0, 0);

    // Reset values.
    #12;
    check_phv("rst_phv_out", phv_out, '0);
    check_bit("rst_valid", 64'(phv_out_valid), 64'd0);
    check_bit("rst_overflow", 64'(overflow_err), 64'd0);
    check_bit("rst_ready_out", 64'(ready_out), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Single PHV, ALU results two cycles after the tail.
    phv_out_ready = 1'b1;
    remain_valid = 1'b1;
    phv_remain_data = REM'(1);
    sb_q.push_back({48'hfffffffffffe, 48'heeeeeeeeeeef, 672'b0, 355'b0, 1'b1});
    step();
    idle();
    step();
    alu_out_6B = {48'hfffffffffffe, 48'heeeeeeeeeeef, 288'b0};
    alu_out_4B = '0;
    alu_out_2B = '0;
    alu_out_6B_valid = 1'b1;
    alu_out_4B_valid = 1'b1;
    alu_out_2B_valid = 1'b1;
    step();
    idle();
    check_bit("align_latency_pre", 64'(phv_out_valid), 64'd0);
    step();
    check_bit("align_valid", 64'(phv_out_valid), 64'd1);
    check_phv("align_data", phv_out,
              {48'hfffffffffffe, 48'heeeeeeeeeeef, 672'b0, 355'b0, 1'b1});
    step();
    check_bit("align_one_cycle", 64'(phv_out_valid), 64'd0);

    // Skewed arrival: tail, 2B, 4B, 6B at cycles 0, 1, 3, 5.
    sb_q.push_back(mk_phv(7));
    send(1, 0, 0, 0, 7); step(); idle();
    check_bit("skew_c0", 64'(phv_out_valid), 64'd0);
    send(0, 0, 0, 1, 7); step(); idle();
    check_bit("skew_c1", 64'(phv_out_valid), 64'd0);
    step();
    send(0, 0, 1, 0, 7); step(); idle();
    check_bit("skew_c3", 64'(phv_out_valid), 64'd0);
    step();
    send(0, 1, 0, 0, 7); step(); idle();
    check_bit("skew_c5", 64'(phv_out_valid), 64'd0);
    step();
    check_bit("skew_valid", 64'(phv_out_valid), 64'd1);
    step();
    step();

    // Table of layout vectors, back-to-back at full throughput.
    for (int i = 0; i < 5; i++) begin
      phv_remain_data = tbl[i].rem;
      alu_out_6B      = tbl[i].d6;
      alu_out_4B      = tbl[i].d4;
      alu_out_2B      = tbl[i].d2;
      remain_valid = 1'b1; alu_out_6B_valid = 1'b1;
      alu_out_4B_valid = 1'b1; alu_out_2B_valid = 1'b1;
      sb_q.push_back(tbl[i].exp);
      step();
      if (i > 0) check_bit("thru_valid", 64'(phv_out_valid), 64'd1);
    end
    idle();
    step();
    step();
    step();

    // Backpressure: three PHVs, output stalled for six cycles.
    phv_out_ready = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      send(1, 1, 1, 1, t);
      sb_q.push_back(mk_phv(t));
      step();
    end
    idle();
    for (int c = 0; c < 6; c++) begin
      check_bit("bp_hold_valid", 64'(phv_out_valid), 64'd1);
      check_bit("bp_hold_tag", 64'(phv_out[63:0]), 64'd1);
      step();
    end
    phv_out_ready = 1'b1;
    step();
    check_bit("bp_tag2", 64'(phv_out[63:0]), 64'd2);
    step();
    check_bit("bp_tag3", 64'(phv_out[63:0]), 64'd3);
    step();
    check_bit("bp_done", 64'(phv_out_valid), 64'd0);
    check_bit("bp_overflow", 64'(overflow_err), 64'd0);

    // Full tail FIFO with a push in the same cycle as a merge.
    reset_dut();
    phv_out_ready = 1'b1;
    for (int t = 20; t <= 23; t++) begin
      send(1, 0, 0, 0, t);
      step();
    end
    idle();
    check_bit("full_ready_out", 64'(ready_out), 64'd0);
    send(0, 1, 1, 1, 20);
    sb_q.push_back(mk_phv(20));
    step();
    send(1, 0, 0, 0, 24);
    step();
    idle();
    check_bit("full_pp_overflow", 64'(overflow_err), 64'd0);
    check_bit("full_pp_ready_out", 64'(ready_out), 64'd0);
    check_bit("full_pp_valid", 64'(phv_out_valid), 64'd1);
    for (int t = 21; t <= 24; t++) begin
      send(0, 1, 1, 1, t);
      sb_q.push_back(mk_phv(t));
      step();
    end
    idle();
    step();
    step();
    check_bit("full_drained_ready", 64'(ready_out), 64'd1);
    check_bit("full_drained_overflow", 64'(overflow_err), 64'd0);

    // Fill and overflow of the tail FIFO.
    for (int k = 0; k < 4; k++) begin
      send(1, 0, 0, 0, 30 + k);
      step();
      check_bit("fill_ready_out", 64'(ready_out), (k < 2) ? 64'd1 : 64'd0);
    end
    check_bit("fill_no_overflow", 64'(overflow_err), 64'd0);
    send(1, 0, 0, 0, 34);
    step();
    idle();
    check_bit("ovf_set", 64'(overflow_err), 64'd1);
    step();
    step();
    check_bit("ovf_sticky", 64'(overflow_err), 64'd1);
    for (int t = 30; t <= 33; t++) begin
      send(0, 1, 1, 1, t);
      sb_q.push_back(mk_phv(t));
      step();
    end
    idle();
    step();
    step();
    check_bit("ovf_after_drain", 64'(overflow_err), 64'd1);
    check_bit("ovf_drained_valid", 64'(phv_out_valid), 64'd0);

    // Asynchronous reset with one PHV on the output and two buffered.
    reset_dut();
    check_bit("rst2_overflow_clr", 64'(overflow_err), 64'd0);
    for (int t = 40; t <= 42; t++) begin
      send(1, 1, 1, 1, t);
      sb_q.push_back(mk_phv(t));
      step();
    end
    idle();
    step();
    check_bit("mid_valid_before", 64'(phv_out_valid), 64'd1);
    #3;
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    check_phv("mid_rst_phv_out", phv_out, '0);
    check_bit("mid_rst_valid", 64'(phv_out_valid), 64'd0);
    check_bit("mid_rst_ready_out", 64'(ready_out), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    phv_out_ready = 1'b1;
    send(1, 1, 1, 1, 50);
    sb_q.push_back(mk_phv(50));
    step();
    idle();
    step();
    check_bit("mid_first_valid", 64'(phv_out_valid), 64'd1);
    check_bit("mid_first_tag", 64'(phv_out[63:0]), 64'd50);
    step();
    check_bit("mid_after_valid", 64'(phv_out_valid), 64'd0);

    // Every expected PHV must have been delivered within a bounded window.
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) step();
    check_bit("sb_drain", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
